// File: rtl/sync_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : sync_pulse_gen
// Brief    : Programmable one-shot / continuous sync pulse generator.
// Revision : 1.0
// ============================================================================
module sync_pulse_gen #(
  parameter int PERIOD_W = 32,
  parameter int WIDTH_W  = 16,
  parameter bit OUT_IDLE = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                mode,
  input  logic [PERIOD_W-1:0] delay,
  input  logic [PERIOD_W-1:0] period,
  input  logic [WIDTH_W-1:0]  width,
  output logic                out,
  output logic                ris,
  output logic                fal,
  output logic                busy,
  output logic [15:0]         pulse_cnt
);

  // Wide enough for both the period and width + 1.
  localparam int CW = (PERIOD_W > WIDTH_W) ? PERIOD_W : WIDTH_W + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DELAY    = 2'd1,
    S_ACTIVE   = 2'd2,
    S_INACTIVE = 2'd3
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [CW-1:0] r_we, r_inact;
  logic          r_mode;
  logic          r_out, r_ris, r_fal, r_busy;
  logic [15:0]   r_pulse_cnt;

  logic [CW-1:0] w_we, w_period, w_pe, w_inact;
  logic          w_latch, w_act, w_ris, w_fal, w_busy;
  logic [15:0]   w_pulse_cnt, w_pulse_inc;

  always_comb begin
    w_we     = (width == '0) ? CW'(1) : CW'(width);
    w_period = CW'(period);
    w_pe     = (w_period > w_we) ? w_period : w_we + CW'(1);
    w_inact  = w_pe - w_we;
  end

  assign w_pulse_inc = (r_pulse_cnt == 16'hFFFF) ? r_pulse_cnt : r_pulse_cnt + 16'd1;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_latch     = 1'b0;
    w_act       = 1'b0;
    w_ris       = 1'b0;
    w_fal       = 1'b0;
    w_busy      = 1'b1;
    w_pulse_cnt = r_pulse_cnt;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start && !stop) begin
          w_latch     = 1'b1;
          w_busy      = 1'b1;
          w_pulse_cnt = 16'd0;
          if (delay == '0) begin
            w_state     = S_ACTIVE;
            w_cnt       = w_we - CW'(1);
            w_act       = 1'b1;
            w_ris       = 1'b1;
            w_pulse_cnt = 16'd1;
          end else begin
            w_state = S_DELAY;
            w_cnt   = CW'(delay) - CW'(1);
          end
        end
      end
      S_DELAY, S_INACTIVE: begin
        if (r_cnt == '0) begin
          w_state     = S_ACTIVE;
          w_cnt       = r_we - CW'(1);
          w_act       = 1'b1;
          w_ris       = 1'b1;
          w_pulse_cnt = w_pulse_inc;
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      S_ACTIVE: begin
        if (r_cnt == '0) begin
          w_fal = 1'b1;
          if (r_mode) begin
            w_state = S_INACTIVE;
            w_cnt   = r_inact - CW'(1);
          end else begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
          end
        end else begin
          w_act = 1'b1;
          w_cnt = r_cnt - CW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Abort: fal only when the pulse was actually being driven.
    if (stop && (r_state != S_IDLE)) begin
      w_state     = S_IDLE;
      w_cnt       = '0;
      w_act       = 1'b0;
      w_ris       = 1'b0;
      w_fal       = (r_state == S_ACTIVE);
      w_busy      = 1'b0;
      w_pulse_cnt = r_pulse_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= '0;
      r_inact     <= '0;
      r_mode      <= 1'b0;
      r_out       <= OUT_IDLE;
      r_ris       <= 1'b0;
      r_fal       <= 1'b0;
      r_busy      <= 1'b0;
      r_pulse_cnt <= 16'd0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_out       <= w_act ? ~OUT_IDLE : OUT_IDLE;
      r_ris       <= w_ris;
      r_fal       <= w_fal;
      r_busy      <= w_busy;
      r_pulse_cnt <= w_pulse_cnt;
      if (w_latch) begin
        r_we    <= w_we;
        r_inact <= w_inact;
        r_mode  <= mode;
      end
    end
  end

  assign out       = r_out;
  assign ris       = r_ris;
  assign fal       = r_fal;
  assign busy      = r_busy;
  assign pulse_cnt = r_pulse_cnt;

endmodule
`default_nettype wire

// File: doc/sync_pulse_gen.md
SYNC_PULSE_GEN -- requirements
Module: sync_pulse_gen

Interface
REQ-001 SHALL have parameter PERIOD_W, default 32, width of delay and period fields in clk cycles.
REQ-002 SHALL have parameter WIDTH_W, default 16, width of pulse-width field in clk cycles.
REQ-003 SHALL have parameter OUT_IDLE, default 0, level of out when no pulse is active; active level is ~OUT_IDLE.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle strobe launching pulse generation.
REQ-007 SHALL have port stop  input  1  one-cycle strobe aborting generation.
REQ-008 SHALL have port mode  input  1  0 = one-shot, 1 = continuous.
REQ-009 SHALL have port delay  input  PERIOD_W  cycles from accepted start to first active cycle.
REQ-010 SHALL have port period  input  PERIOD_W  cycles per pulse period, active plus inactive.
REQ-011 SHALL have port width  input  WIDTH_W  active cycles per pulse.
REQ-012 SHALL have port out  output  1  generated sync signal, registered.
REQ-013 SHALL have port ris  output  1  one-cycle strobe, high in the first cycle out is at the active level.
REQ-014 SHALL have port fal  output  1  one-cycle strobe, high in the first cycle out returns to OUT_IDLE.
REQ-015 SHALL have port busy  output  1  high while the generator is not in IDLE.
REQ-016 SHALL have port pulse_cnt  output  16  pulses emitted since the last accepted start, saturating.

Function
REQ-017 SHALL implement states IDLE, DELAY, ACTIVE and INACTIVE; all outputs SHALL be registered.
REQ-018 SHALL accept start only in IDLE with stop low; start while busy SHALL be ignored.
REQ-019 SHALL latch mode, delay, period and width on the accepted start; input changes while busy SHALL have no effect.
REQ-020 SHALL treat width = 0 as width 1 (effective width We).
REQ-021 SHALL set effective period Pe = period when period > We, else Pe = We + 1, so at least one inactive cycle exists.
REQ-022 SHALL, for start sampled at edge k with delay = 0, enter ACTIVE with out active from cycle k+1.
REQ-023 SHALL, for start sampled at edge k with delay = D > 0, stay in DELAY for D cycles with out = OUT_IDLE and enter ACTIVE at cycle k+1+D.
REQ-024 SHALL hold ACTIVE for We cycles, then go to IDLE in one-shot mode or to INACTIVE for Pe - We cycles in continuous mode.
REQ-025 SHALL go from INACTIVE to ACTIVE with no gap cycle, so rising edges are exactly Pe cycles apart.
REQ-026 SHALL assert ris in the first ACTIVE cycle of each pulse and fal in the cycle after the last ACTIVE cycle, each for exactly one cycle.
REQ-027 SHALL assert busy from the cycle after the accepted start through the last ACTIVE or INACTIVE cycle; busy SHALL be low in the same cycle fal is asserted on one-shot completion.
REQ-028 SHALL clear pulse_cnt on an accepted start, increment it with each ris, and saturate it at 16'hFFFF.
REQ-029 SHALL, on stop in any non-IDLE state, enter IDLE next cycle with out = OUT_IDLE and busy = 0.
REQ-030 SHALL assert fal on that cycle only if out was active when stop was sampled.
REQ-031 SHALL give stop priority over start when both are high in the same cycle; stop in IDLE SHALL have no effect.
REQ-032 SHALL hold pulse_cnt unchanged on stop.

Reset
REQ-033 SHALL, with reset high at a clk edge, set state IDLE, out = OUT_IDLE, ris = 0, fal = 0, busy = 0 and pulse_cnt = 0 in the next cycle.
REQ-034 SHALL, on reset during ACTIVE, return out to OUT_IDLE without asserting fal.
REQ-035 SHALL give reset priority over start and stop.

Verification
REQ-036 One-shot, delay=0, width=3, period=10, start at k -> out active k+1..k+3; ris at k+1; fal at k+4; busy high k+1..k+3; pulse_cnt=1.
REQ-037 Continuous, delay=2, width=2, period=5 -> out active k+3,k+4 then k+8,k+9 then k+13,k+14; ris at k+3, k+8, k+13; pulse_cnt 1, 2, 3.
REQ-038 Continuous, width=4, period=4 -> 4 active cycles and 1 inactive cycle, rising edges 5 cycles apart; width=0 -> 1 active cycle.
REQ-039 stop during the 2nd ACTIVE cycle -> out idle and fal=1 next cycle, busy=0; stop during INACTIVE -> no fal; pulse_cnt held.
REQ-040 start while busy -> ignored, timing unchanged; start and stop together in IDLE -> stays IDLE; period changed mid-run -> no effect.
REQ-041 reset mid-ACTIVE with OUT_IDLE=1 -> out=1 next cycle, fal=0, pulse_cnt=0, busy=0.
